// File: rtl/clk_div.sv
// clk_div: programmable square-wave clock divider with per-toggle tick pulse.
//   Half-period of clkdiv is upperbound+1 clk cycles; full period 2*(upperbound+1).
//   Optional macro CLK_DIV_UB_LATCH_EN: latch upperbound at each half-period start
//   so that changes only take effect on half-period boundaries.
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   upperbound  in   WIDTH  half-period minus one, in clk cycles
//   clkdiv      out  1      divided clock (registered)
//   tick        out  1      one-cycle pulse in the cycle clkdiv toggles (registered)
module clk_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] upperbound,
    output logic             clkdiv,
    output logic             tick
);
    logic [WIDTH-1:0] cnt_q, cnt_d, eb;
    logic             clkdiv_q, clkdiv_d, tick_q, tick_d, hit;
`ifdef CLK_DIV_UB_LATCH_EN
    logic [WIDTH-1:0] ub_q, ub_d;
    // A new half-period starts at cnt==0: take the live bound and remember it.
    always_comb begin
        eb   = (cnt_q == '0) ? upperbound : ub_q;
        ub_d = eb;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ub_q <= '0;
        else        ub_q <= ub_d;
`else
    assign eb = upperbound;
`endif
    // >= rather than == so a bound lowered below cnt ends the half at once.
    always_comb begin
        hit      = cnt_q >= eb;
        cnt_d    = hit ? '0 : cnt_q + 1'b1;
        clkdiv_d = hit ? ~clkdiv_q : clkdiv_q;
        tick_d   = hit;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q    <= '0;
            clkdiv_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clkdiv_q <= clkdiv_d;
            tick_q   <= tick_d;
        end
    assign clkdiv = clkdiv_q;
    assign tick   = tick_q;
endmodule

// File: tb/tb_clk_div.sv
// tb_clk_div: self-checking bench for clk_div (directed scenarios plus randomized model compare).
module tb_clk_div;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] upperbound = 32'd5;
    logic        clkdiv, tick;
    int          checks = 0;
    int          errors = 0;

    clk_div #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .upperbound(upperbound), .clkdiv(clkdiv), .tick(tick)
    );

    always #10 clk = ~clk;

    // Reference model: m_el = edges already spent in the current half-period,
    // a half is complete on the edge that brings it to bound+1 edges.
    longint m_el = 0;
    logic   m_div = 1'b0, m_tick = 1'b0;
`ifdef CLK_DIV_UB_LATCH_EN
    longint m_len = 0;
`endif
    always @(posedge clk or negedge rst_n) begin
        longint bound;
        if (!rst_n) begin
            m_el = 0; m_div = 1'b0; m_tick = 1'b0;
        end else begin
`ifdef CLK_DIV_UB_LATCH_EN
            if (m_el == 0) m_len = longint'(upperbound);
            bound = m_len;
`else
            bound = longint'(upperbound);
`endif
            if (m_el + 1 >= bound + 1) begin
                m_el = 0; m_div = ~m_div; m_tick = 1'b1;
            end else begin
                m_el = m_el + 1; m_tick = 1'b0;
            end
        end
    end

    // Waits for the next clkdiv change; n = edges taken, -1 if none within 100 edges.
    task automatic edges_to_toggle(output int n);
        logic start;
        start = clkdiv;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (clkdiv !== start) begin n = i; return; end
        end
        n = -1;
    endtask

    // Holds reset 3 cycles with the given bound, checking outputs, releases at a negedge.
    task automatic do_reset(input logic [31:0] ub);
        @(negedge clk);
        rst_n = 1'b0;
        upperbound = ub;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (clkdiv !== 1'b0 || tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: clkdiv=%b tick=%b required 0 0", i, clkdiv, tick);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(32'd5);
        upperbound = 32'd0;
        @(posedge clk); #1;
        if (clkdiv !== 1'b1) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clkdiv !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: clkdiv=%b tick=%b required 0 0", clkdiv, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_toggle;
        int n;
        do_reset(32'd5);
        edges_to_toggle(n);
        checks++;
        if (n !== 6 || clkdiv !== 1'b1) begin
            errors++;
            $display("FAIL first_rise: edges=%0d clkdiv=%b required 6 1", n, clkdiv);
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_on_toggle: tick=%b required 1", tick);
        end
        @(posedge clk); #1;
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_one_cycle: tick=%b required 0", tick);
        end
        edges_to_toggle(n);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL half_period_ub5: edges=%0d required 5 more", n);
        end
    endtask

    task automatic test_drop;
        int n, exp_first;
`ifdef CLK_DIV_UB_LATCH_EN
        exp_first = 3;
`else
        exp_first = 1;
`endif
        do_reset(32'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        upperbound = 32'd1;
        edges_to_toggle(n);
        checks++;
        if (n !== exp_first) begin
            errors++;
            $display("FAIL drop_first: edges=%0d required %0d", n, exp_first);
        end
        for (int i = 0; i < 4; i++) begin
            edges_to_toggle(n);
            checks++;
            if (n !== 2) begin
                errors++;
                $display("FAIL drop_period half%0d: edges=%0d required 2", i, n);
            end
        end
    endtask

    task automatic test_ub0;
        do_reset(32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (clkdiv !== ((i % 2) == 0) || tick !== 1'b1) begin
                errors++;
                $display("FAIL ub0 edge%0d: clkdiv=%b tick=%b required %b 1", i + 1, clkdiv, tick, (i % 2) == 0);
            end
        end
    endtask

    task automatic test_increase;
        int n, exp_cur;
`ifdef CLK_DIV_UB_LATCH_EN
        exp_cur = 3;
`else
        exp_cur = 8;
`endif
        do_reset(32'd2);
        @(posedge clk);
        @(negedge clk);
        upperbound = 32'd7;
        edges_to_toggle(n);
        checks++;
        if (n + 1 !== exp_cur) begin
            errors++;
            $display("FAIL increase_current: half=%0d required %0d", n + 1, exp_cur);
        end
        edges_to_toggle(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL increase_next: half=%0d required 8", n);
        end
    endtask

    task automatic test_duty;
        int n;
        do_reset(32'd3);
        edges_to_toggle(n);
        for (int i = 0; i < 20; i++) begin
            edges_to_toggle(n);
            checks++;
            if (n !== 4) begin
                errors++;
                $display("FAIL duty run%0d (%s): len=%0d required 4", i, clkdiv ? "low" : "high", n);
            end
        end
    endtask

    task automatic test_random;
        do_reset($urandom_range(0, 9));
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++;
            if (clkdiv !== m_div || tick !== m_tick) begin
                errors++;
                $display("FAIL random cyc%0d ub=%0d: clkdiv=%b tick=%b required %b %b", i, upperbound, clkdiv, tick, m_div, m_tick);
            end
            if ($urandom_range(0, 7) == 0)
                upperbound = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 9));
        end
    endtask

    initial begin
        test_reset();
        test_first_toggle();
        test_drop();
        test_ub0();
        test_increase();
        test_duty();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
